// File: rtl/dotprod_seq_if.sv
// rtl/dotprod_seq_if.sv - command, element and result channels of the dot-product sequencer
interface dotprod_seq_if #(
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [10:0]       cmd_len;
    logic              cmd_chain;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_len, cmd_chain, in_valid, in_a, in_b, res_ready,
        input  cmd_ready, in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_chain, in_valid, in_a, in_b, res_ready,
        output cmd_ready, in_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/dotprod_seq.sv
// rtl/dotprod_seq.sv - loads the main kernel's operand arrays, starts it and returns its dot product
// Chained accumulation (seed from the last good result) is built when DOTSEQ_CHAIN_EN is defined.
module dotprod_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64,
    parameter int LIMIT  = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    dotprod_seq_if.slave      bus,
    output logic              busy,
    output logic              k_r_enable,
    output logic              k_controlArr,
    output logic [ADDR_W-1:0] k_init_i,
    output logic [ACC_W-1:0]  k_init_acc,
    output logic              k_controlArrWEnable_a,
    output logic              k_controlArrWEnable_b,
    output logic [ADDR_W-1:0] k_controlArrAddr_a,
    output logic [ADDR_W-1:0] k_controlArrAddr_b,
    output logic [DATA_W-1:0] k_controlArrWData_a,
    output logic [DATA_W-1:0] k_controlArrWData_b,
    input  logic              k_w_enable,
    input  logic [ACC_W-1:0]  k_result
);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, addr, cmd_base, start_base;
    logic [ACC_W-1:0]  res_data_q, seed;
    logic              res_err_q, cmd_ready_q;
    logic              cmd_fire, in_fire, len_bad, len_zero, last_elem;

    assign cmd_base   = ADDR_W'(LIMIT - 32'(bus.cmd_len));
    assign len_bad    = 32'(bus.cmd_len) > 32'(LIMIT);
    assign len_zero   = (bus.cmd_len == '0);
    assign cmd_fire   = bus.cmd_valid && cmd_ready_q;
    assign in_fire    = (state == LOAD) && bus.in_valid;
    assign last_elem  = (addr == ADDR_W'(LIMIT - 1));
    // A zero-length command enters START straight from IDLE, before base is registered.
    assign start_base = (state == IDLE) ? cmd_base : base;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt             = state;
        busy                  = (state != IDLE);
        k_controlArr          = (state == LOAD);
        bus.in_ready          = (state == LOAD);
        bus.res_valid         = (state == RESP);
        k_controlArrWEnable_a = in_fire;
        k_controlArrWEnable_b = in_fire;
        k_controlArrAddr_a    = addr;
        k_controlArrAddr_b    = addr;
        k_controlArrWData_a   = bus.in_a;
        k_controlArrWData_b   = bus.in_b;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = len_bad ? RESP : (len_zero ? START : LOAD);
            LOAD:    if (in_fire && last_elem) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (k_w_enable) state_nxt = RESP;
            RESP:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base        <= '0;
            addr        <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            k_r_enable  <= 1'b0;
            k_init_i    <= '0;
            k_init_acc  <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_nxt == IDLE);
            k_r_enable  <= (state_nxt == START);
            if (cmd_fire) begin
                base <= cmd_base;
                addr <= cmd_base;
                if (len_bad) begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
            end
            if (in_fire) addr <= addr + 1'b1;
            if (state_nxt == START) begin
                k_init_i   <= start_base;
                k_init_acc <= seed;
            end
            if (state == RUN && k_w_enable) begin
                res_data_q <= k_result;
                res_err_q  <= 1'b0;
            end
        end
    end

`ifdef DOTSEQ_CHAIN_EN
    logic             chain_q;
    logic [ACC_W-1:0] last_ok_result;

    assign seed = ((state == IDLE) ? bus.cmd_chain : chain_q) ? last_ok_result : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q        <= 1'b0;
            last_ok_result <= '0;
        end else begin
            if (cmd_fire) chain_q <= bus.cmd_chain;
            if (state == RESP && bus.res_ready && !res_err_q) last_ok_result <= res_data_q;
        end
    end
`else
    logic unused_chain;
    assign unused_chain = bus.cmd_chain;
    assign seed         = '0;
`endif
endmodule

// File: doc/dotprod_seq.md
# dotprod_seq

Host-side sequencer for the `main` dot-product kernel and its two 1024×27 operand arrays (`arr_a`/`arr_b`). It accepts a command with a vector length, streams `len` element pairs into the arrays through the kernel's `controlArr` port, and starts the kernel. It then waits for `w_enable`, returns the 64-bit result on a valid/ready channel, and owns the array port for the whole transaction.

## Interface
Parameters:
- `ADDR_W`, 10: array address width.
- `DATA_W`, 27: signed element width.
- `ACC_W`, 64: signed accumulator/result width.
- `LIMIT`, 1000: kernel loop bound (exit when `i == LIMIT`).

Ports:
- `clk`  in  1: clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`/`cmd_ready`  in/out  1: command handshake.
- `cmd_len`  in  11: vector length.
- `cmd_chain`  in  1: seed the accumulator with the previous result. Used only with `DOTSEQ_CHAIN_EN`.
- `in_valid`/`in_ready`  in/out  1: element handshake.
- `in_a`, `in_b`  in  DATA_W: signed operands.
- `res_valid`/`res_ready`  out/in  1: result handshake.
- `res_data`  out  ACC_W: signed dot product.
- `res_err`  out  1: command rejected.
- `busy`  out  1: high in every state except IDLE.
- `k_r_enable`, `k_controlArr`  out  1: kernel start and array-ownership controls.
- `k_init_i`  out  ADDR_W; `k_init_acc`  out  ACC_W: kernel seeds.
- `k_controlArrWEnable_a/_b`  out  1; `k_controlArrAddr_a/_b`  out  ADDR_W; `k_controlArrWData_a/_b`  out  DATA_W: array write ports.
- `k_w_enable`  in  1; `k_result`  in  ACC_W: kernel completion and value.

## Operation
States are IDLE, LOAD, START, RUN and RESP.

- **IDLE**
  - `cmd_ready=1`.
  - On handshake: latch `len`, `base = LIMIT - len` (ADDR_W bits), `addr = base`.
  - `len > LIMIT` → RESP with `res_err=1` and `res_data=0`; the kernel is not touched.
  - `len == 0` → START.
  - Otherwise → LOAD.
- **LOAD**
  - `k_controlArr=1` and `in_ready=1`.
  - Each `in` handshake drives both write enables for that cycle, with `addr` on both address ports, `in_a` on `_a` data and `in_b` on `_b` data. `addr` then increments.
  - The handshake that writes address `LIMIT-1` moves to START.
  - `in_ready=0` in every other state.
- **START**
  - One cycle with `k_controlArr=0`, `k_r_enable=1`, `k_init_i=base`, `k_init_acc=seed`.
  - `seed` is 0; see Configuration for the chained case.
  - Next state is RUN.
- **RUN**
  - `k_controlArr=0`, `k_r_enable=0`.
  - When `k_w_enable=1`: capture `k_result` into `res_data`, set `res_err=0`, go to RESP.
- **RESP**
  - `res_valid=1`; `res_data` and `res_err` are held stable.
  - On `res_ready` → IDLE.

Outputs:
- `k_init_i` and `k_init_acc` are held at their last values outside START.
- All write enables are 0 outside LOAD handshakes.
- Kernel arithmetic is signed: operands are sign-extended by the kernel. The sequencer performs no arithmetic on data.

## Timing
Reset values (asynchronous, whole block): state = IDLE.
- All kernel controls, enables and addresses are 0.
- `res_data = 0`, `res_err = 0`, `res_valid = 0`.
- `cmd_ready = 1` one cycle after `rst_n` deasserts.

Array contents are not cleared.

Cycle behaviour:
- Load runs at one element per cycle at full throughput, with no bubble at the IDLE→LOAD or LOAD→START transitions.
- `k_r_enable` is registered and exactly one cycle wide.
- `k_w_enable` is sampled only in RUN. START's `r_enable` edge clears the kernel's `w_enable`, so stale values are never seen.
- Kernel compute takes 6 cycles per element plus exit overhead (set by the kernel). The sequencer adds START (1 cycle) and the result capture (1 cycle).
- The result channel is valid/ready: `res_valid` holds until accepted, and the next command is not accepted in the same cycle that `res_ready` is accepted.

Boundary conditions:
- `len == LIMIT`: `base = 0`, and `addr` ends at `LIMIT-1` with no wrap.
- `len == 0`: the kernel returns the seed immediately.
- `cmd_valid` while busy: ignored (`cmd_ready=0`).
- `rst_n` low mid-LOAD or mid-RUN: return to IDLE at once and drop `k_controlArr`. The kernel may keep running but is restarted by the next START.

## Configuration
- **`DOTSEQ_CHAIN_EN` defined:**
  - `seed = cmd_chain ? last_ok_result : 0`.
  - `last_ok_result` is a register, reset to 0, updated on every non-error RESP acceptance.
- **`DOTSEQ_CHAIN_EN` undefined:**
  - `cmd_chain` is ignored and `seed` is always 0.
  - No `last_ok_result` register is built.

## Test plan
- `len=3`, a={1,2,3}, b={4,5,6} → writes to addresses 997..999, `k_init_i=997`, `res_data=32`, `res_err=0`.
- `len=2`, a={-1,-67108864}, b={5,2} → `res_data=-134217733`. Sign extension is correct.
- `len=0` → no `in_ready`, one `k_r_enable` pulse with `k_init_i=1000`, `res_data=0`. `len=1001` → `res_err=1`, `res_data=0`, `k_r_enable` never asserted.
- `len=4` with `in_valid` toggling every other cycle and `res_ready` held low for 10 cycles → correct sum; `res_valid`/`res_data` stable until accepted; `cmd_ready=0` throughout.
- `rst_n` pulsed low after 2 of 5 elements → all outputs at reset values immediately. A new `len=1` command, a=7, b=3 → `res_data=21`.
- With `DOTSEQ_CHAIN_EN`: `len=1`, a=2, b=3, `cmd_chain=0` → 6. Then `len=1`, a=2, b=3, `cmd_chain=1` → `k_init_acc=6`, `res_data=12`.
